spi_flash_seq: RTL and testbench
================================

SPI_FLASH_SEQ -- requirements
Module: spi_flash_seq

Interface
REQ-001 Parameter ACK_TO, default 24'd2_000_000, SHALL set the cycles allowed per bus access before timeout.
REQ-002 Parameter POLL_MAX, default 16'd50000, SHALL set the maximum status polls per operation.
REQ-003 CLK  in  1  SHALL be the single clock; all logic is posedge CLK.
REQ-004 RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 START  in  1  SHALL be a one-cycle request pulse.
REQ-006 OP  in  2  SHALL select the operation: 0 sector erase, 1 page program, 2 read status, 3 reserved.
REQ-007 FADDR  in  24  SHALL be the flash byte address.
REQ-008 LEN  in  9  SHALL be the page-program byte count, valid range 1..256.
REQ-009 BUSY  out  1  SHALL be high from START acceptance until DONE.
REQ-010 DONE  out  1  SHALL be a one-cycle completion pulse.
REQ-011 ERR  out  2  SHALL be the error code: 0 ok, 1 bad request, 2 ack timeout, 3 poll limit; held until next accepted START.
REQ-012 STATUS  out  8  SHALL be the last flash status byte read.
REQ-013 M_ACT, M_WE, M_RE  out  1 each  SHALL be the RBCP-style master strobes toward the SPI interface.
REQ-014 M_ADDR  out  12  SHALL be the master address; M_WD  out  8  SHALL be the master write data.
REQ-015 M_ACK  in  1  SHALL be the access acknowledge; M_RD  in  8  SHALL be the read data, valid with M_ACK.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, NEXT, CHECK, FIN; START SHALL be accepted only in IDLE and ignored otherwise.
REQ-017 Acceptance SHALL latch OP/FADDR/LEN; OP=3, or OP=1 with LEN=0 or LEN>256, SHALL go directly to FIN with ERR=1 and issue no access.
REQ-018 Each access SHALL be a step (addr, data, write/read) taken from a fixed step list indexed by a 6-bit step counter.
REQ-019 ISSUE SHALL assert M_ACT and exactly one of M_WE/M_RE for one cycle; M_ACT SHALL stay high through WAIT until the M_ACK cycle inclusive.
REQ-020 M_ADDR/M_WD SHALL be stable from ISSUE until M_ACK.
REQ-021 WAIT SHALL count cycles; count reaching ACK_TO SHALL drop M_ACT and go to FIN with ERR=2.
REQ-022 Transaction step list, write address:value: 0x05:0x80, 0x06:0x00, 0x07:0x01, 0x08:cmd, 0x09:A[23:16], 0x0A:A[15:8], 0x0B:A[7:0]; the 0x0B write launches the SPI transfer, and its M_ACK marks transfer end.
REQ-023 Setup SHALL precede each operation: writes 0x01:0x00, 0x02:0x00, 0x03:0x00, 0x04:0x00.
REQ-024 OP=0 sequence SHALL be: setup, WREN (cmd 0x06, 0x05:0x80, length 1), SE (cmd 0xD8, 0x05:0x83, length 4, address FADDR), then poll.
REQ-025 OP=1 sequence SHALL be: setup, WREN, PP (cmd 0x02, 0x05:0x83, length 4+LEN as 16 bits in 0x06/0x07, address FADDR), then poll; page data is pre-loaded in the buffer by the host.
REQ-026 OP=2 sequence SHALL be: setup, then a single poll pass.
REQ-027 A poll pass SHALL be: RDSR transaction (cmd 0x05, 0x05:0x00, length 2, address bytes 0x00), then read of 0x800; M_RD SHALL be captured into STATUS on M_ACK.
REQ-028 CHECK SHALL end with ERR=0 if STATUS[0]==0 (or OP=2); otherwise it SHALL increment the poll count and repeat the poll pass, going to ERR=3 when the count reaches POLL_MAX.
REQ-029 FIN SHALL pulse DONE for one cycle, clear BUSY in the same cycle, and return to IDLE.
REQ-030 START coincident with FIN SHALL be ignored.

Reset
REQ-031 RST SHALL force IDLE; BUSY, DONE, M_ACT, M_WE and M_RE SHALL go to 0; M_ADDR, M_WD, ERR and STATUS SHALL go to 0; the step, poll and timeout counters SHALL be cleared.
REQ-032 RST mid-operation SHALL abandon the sequence without DONE, and a late M_ACK after reset SHALL be ignored.

Verification
REQ-033 OP=2, flash model status 0x00 -> write sequence 0x01..0x04, then 0x05..0x0B with 0x08=0x05, then read 0x800; STATUS=0x00, ERR=0, one DONE pulse.
REQ-034 OP=0, FADDR=0x1A0000, WIP=1 for 3 polls -> WREN then SE with 0x09/0x0A/0x0B=0x1A/0x00/0x00; exactly 4 RDSR passes; ERR=0.
REQ-035 OP=1, LEN=256 -> 0x06=0x01, 0x07=0x04, cmd 0x02; OP=1, LEN=0 -> DONE with ERR=1 and no M_ACT.
REQ-036 M_ACK withheld with ACK_TO=100 -> M_ACT drops after 100 cycles, ERR=2; WIP stuck with POLL_MAX=5 -> ERR=3 after 5 polls.
REQ-037 START while BUSY -> ignored, no sequence change; RST asserted during the SE wait -> all outputs 0, IDLE, no DONE.

Source files
------------

// File: rtl/spi_flash_seq.sv
// SPI flash operation sequencer. Drives a byte-wide RBCP-style register master
// through fixed step lists for sector erase, page program and status read,
// polling the flash status register until the write-in-progress bit clears.
//
//  state | meaning
//  IDLE  | waiting for a start request
//  ISSUE | one-cycle access strobe (m_act plus m_we or m_re)
//  WAIT  | m_act held, waiting for m_ack with a timeout down-counter
//  NEXT  | advance the step counter or leave the step list
//  CHECK | evaluate the status byte after a poll pass
//  FIN   | one-cycle done pulse, back to IDLE

module spi_flash_seq #(
    parameter logic [23:0] ACK_TO   = 24'd2_000_000,
    parameter logic [15:0] POLL_MAX = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [23:0] faddr,
    input  logic [8:0]  len,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [7:0]  status,
    output logic        m_act,
    output logic        m_we,
    output logic        m_re,
    output logic [11:0] m_addr,
    output logic [7:0]  m_wd,
    input  logic        m_ack,
    input  logic [7:0]  m_rd
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, CHECK, FIN} state_t;

    // Step layout: 0-3 setup, 4-10 WREN, 11-17 SE/PP, 18-24 RDSR, 25 status read.
    // A status-only request jumps from the last setup step straight to RDSR.
    localparam logic [5:0] STEP_SETUP_LAST = 6'd3;
    localparam logic [5:0] STEP_MAIN       = 6'd11;
    localparam logic [5:0] STEP_POLL       = 6'd18;
    localparam logic [5:0] STEP_READ       = 6'd25;

    state_t      state, state_nxt;
    logic [1:0]  op_q, op_nxt;
    logic [23:0] faddr_q, faddr_nxt;
    logic [8:0]  len_q, len_nxt;
    logic [5:0]  step, step_nxt;
    logic [15:0] poll_cnt, poll_nxt;
    logic [23:0] to_cnt, to_nxt;
    logic [1:0]  err_nxt;
    logic [7:0]  status_nxt;
    logic        bad_req;

    logic [11:0] step_addr;
    logic [7:0]  step_data;
    logic        step_rd;
    logic [2:0]  rel;
    logic [15:0] pp_len;

    // One byte of a 7-write SPI transaction (control, length hi/lo, command, address).
    function automatic logic [7:0] txn_byte(input logic [2:0]  idx,
                                            input logic [7:0]  ctrl,
                                            input logic [15:0] nbytes,
                                            input logic [7:0]  cmd,
                                            input logic [23:0] a);
        case (idx)
            3'd0:    txn_byte = ctrl;
            3'd1:    txn_byte = nbytes[15:8];
            3'd2:    txn_byte = nbytes[7:0];
            3'd3:    txn_byte = cmd;
            3'd4:    txn_byte = a[23:16];
            3'd5:    txn_byte = a[15:8];
            default: txn_byte = a[7:0];
        endcase
    endfunction

    // Decode the current step into master address, write data and direction.
    always_comb begin
        step_addr = 12'h000;
        step_data = 8'h00;
        step_rd   = 1'b0;
        rel       = 3'd0;
        pp_len    = {7'd0, len_q} + 16'd4;
        if (step <= STEP_SETUP_LAST) begin
            step_addr = {6'd0, step} + 12'd1;
        end else if (step < STEP_MAIN) begin
            rel       = step[2:0] - 3'd4;
            step_addr = 12'h005 + {9'd0, rel};
            step_data = txn_byte(rel, 8'h80, 16'd1, 8'h06, 24'd0);
        end else if (step < STEP_POLL) begin
            rel       = step[2:0] - 3'd3;
            step_addr = 12'h005 + {9'd0, rel};
            if (op_q == 2'd1)
                step_data = txn_byte(rel, 8'h83, pp_len, 8'h02, faddr_q);
            else
                step_data = txn_byte(rel, 8'h83, 16'd4, 8'hD8, faddr_q);
        end else if (step < STEP_READ) begin
            rel       = step[2:0] - 3'd2;
            step_addr = 12'h005 + {9'd0, rel};
            step_data = txn_byte(rel, 8'h00, 16'd2, 8'h05, 24'd0);
        end else begin
            step_addr = 12'h800;
            step_rd   = 1'b1;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        faddr_nxt  = faddr_q;
        len_nxt    = len_q;
        step_nxt   = step;
        poll_nxt   = poll_cnt;
        to_nxt     = to_cnt;
        err_nxt    = err;
        status_nxt = status;
        bad_req    = (op == 2'd3) || ((op == 2'd1) && ((len == 9'd0) || (len > 9'd256)));
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt    = op;
                    faddr_nxt = faddr;
                    len_nxt   = len;
                    step_nxt  = 6'd0;
                    poll_nxt  = 16'd0;
                    to_nxt    = 24'd0;
                    if (bad_req) begin
                        err_nxt   = 2'd1;
                        state_nxt = FIN;
                    end else begin
                        err_nxt   = 2'd0;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                to_nxt    = ACK_TO - 24'd1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (m_ack) begin
                    if (step_rd) status_nxt = m_rd;
                    to_nxt    = 24'd0;
                    state_nxt = NEXT;
                end else if (to_cnt == 24'd0) begin
                    err_nxt   = 2'd2;
                    state_nxt = FIN;
                end else begin
                    to_nxt = to_cnt - 24'd1;
                end
            end
            NEXT: begin
                if (step == STEP_READ) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = ISSUE;
                    if ((step == STEP_SETUP_LAST) && (op_q == 2'd2))
                        step_nxt = STEP_POLL;
                    else
                        step_nxt = step + 6'd1;
                end
            end
            CHECK: begin
                if ((op_q == 2'd2) || !status[0]) begin
                    err_nxt   = 2'd0;
                    state_nxt = FIN;
                end else if ((poll_cnt + 16'd1) >= POLL_MAX) begin
                    poll_nxt  = poll_cnt + 16'd1;
                    err_nxt   = 2'd3;
                    state_nxt = FIN;
                end else begin
                    poll_nxt  = poll_cnt + 16'd1;
                    step_nxt  = STEP_POLL;
                    state_nxt = ISSUE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 2'd0;
            faddr_q  <= 24'd0;
            len_q    <= 9'd0;
            step     <= 6'd0;
            poll_cnt <= 16'd0;
            to_cnt   <= 24'd0;
            err      <= 2'd0;
            status   <= 8'd0;
        end else begin
            state    <= state_nxt;
            op_q     <= op_nxt;
            faddr_q  <= faddr_nxt;
            len_q    <= len_nxt;
            step     <= step_nxt;
            poll_cnt <= poll_nxt;
            to_cnt   <= to_nxt;
            err      <= err_nxt;
            status   <= status_nxt;
        end
    end

    // Address and data are forced to zero whenever no access is in flight.
    assign busy   = (state == ISSUE) || (state == WAIT) || (state == NEXT) || (state == CHECK);
    assign done   = (state == FIN);
    assign m_act  = (state == ISSUE) || (state == WAIT);
    assign m_we   = (state == ISSUE) && !step_rd;
    assign m_re   = (state == ISSUE) && step_rd;
    assign m_addr = m_act ? step_addr : 12'h000;
    assign m_wd   = (m_act && !step_rd) ? step_data : 8'h00;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Bench for spi_flash_seq: a flash/RBCP responder with random ack latency,
// a queue-based model of the expected access list, directed and random ops.

module tb_spi_flash_seq;

    localparam logic [23:0] ACK_TO_T   = 24'd100;
    localparam logic [15:0] POLL_MAX_T = 16'd5;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [23:0] faddr;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [7:0]  status;
    logic        m_act;
    logic        m_we;
    logic        m_re;
    logic [11:0] m_addr;
    logic [7:0]  m_wd;
    logic        m_ack;
    logic [7:0]  m_rd;

    spi_flash_seq #(.ACK_TO(ACK_TO_T), .POLL_MAX(POLL_MAX_T)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .faddr(faddr), .len(len),
        .busy(busy), .done(done), .err(err), .status(status),
        .m_act(m_act), .m_we(m_we), .m_re(m_re), .m_addr(m_addr), .m_wd(m_wd),
        .m_ack(m_ack), .m_rd(m_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    // {read, addr[11:0], wdata[7:0]}
    logic [20:0] obs[$];
    logic [20:0] exp_q[$];

    // Written by the main sequence only.
    int   wip_n = 0;
    bit   st_rand = 1'b1;
    int   stall_idx = -1;
    bit   stall_release = 1'b0;
    int   op_seq = 0;
    logic [7:0] exp_status = 8'h00;

    // Written by the responder only.
    int   seen_seq = 0;
    int   rd_k = 0;
    int   rd_acks = 0;
    logic [7:0] last_status = 8'h00;

    // Written by the monitor only.
    int   done_cnt = 0;
    int   act_cyc = 0;
    int   wait_run = 0;
    int   last_wait_run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nchecks++;
        assert (got === want) else begin
            nerrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Flash / register-bus responder.
    initial begin : responder
        logic [11:0] a;
        logic [7:0]  d;
        logic        r;
        logic [7:0]  v;
        int          dly;
        m_ack = 1'b0;
        m_rd  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (op_seq != seen_seq) begin
                seen_seq = op_seq;
                rd_k = 0;
            end
            if (!rst && m_act && (m_we || m_re)) begin
                chk("strobe_onehot", m_we ^ m_re, 1);
                a = m_addr;
                r = m_re;
                d = r ? 8'h00 : m_wd;
                obs.push_back({r, a, d});
                if (obs.size() - 1 == stall_idx) begin
                    wait (stall_release);
                    @(posedge clk); #1;
                    m_rd  = 8'hA5;
                    m_ack = 1'b1;
                    @(posedge clk); #1;
                    m_ack = 1'b0;
                end else begin
                    dly = $urandom_range(1, 4);
                    repeat (dly) begin @(posedge clk); #1; end
                    chk("act_held", m_act, 1);
                    chk("addr_stable", m_addr, a);
                    if (!r) chk("wd_stable", m_wd, d);
                    if (r) begin
                        v = st_rand ? 8'($urandom_range(0, 255)) : 8'h00;
                        v[0] = (rd_k < wip_n);
                        m_rd = v;
                        rd_k++;
                        rd_acks++;
                        last_status = v;
                    end
                    m_ack = 1'b1;
                    @(posedge clk); #1;
                    m_ack = 1'b0;
                    chk("act_drop", m_act, 0);
                end
            end
        end
    end

    // Done-pulse, activity and wait-length monitor.
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
            end
            if (m_act) act_cyc++;
            if (m_act && !m_we && !m_re) begin
                wait_run++;
            end else begin
                if (wait_run != 0) last_wait_run = wait_run;
                wait_run = 0;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic add_w(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, a, d});
    endtask

    task automatic add_txn(input logic [7:0] ctrl, input int nbytes, input logic [7:0] cmd,
                           input logic [23:0] a);
        logic [15:0] n16;
        n16 = nbytes[15:0];
        add_w(12'h005, ctrl);
        add_w(12'h006, n16[15:8]);
        add_w(12'h007, n16[7:0]);
        add_w(12'h008, cmd);
        add_w(12'h009, a[23:16]);
        add_w(12'h00A, a[15:8]);
        add_w(12'h00B, a[7:0]);
    endtask

    // Reference: expected access list, error code and poll count for one request.
    task automatic build(input logic [1:0] o, input logic [23:0] fa, input logic [8:0] ln,
                         input int wip, output logic [1:0] eerr, output int passes, output bit bad);
        exp_q.delete();
        bad = (o == 2'd3) || (o == 2'd1 && (ln == 0 || ln > 256));
        if (bad) begin
            eerr = 2'd1;
            passes = 0;
            return;
        end
        for (int i = 1; i <= 4; i++) add_w(12'(i), 8'h00);
        if (o == 2'd2) begin
            passes = 1;
            eerr = 2'd0;
        end else begin
            add_txn(8'h80, 1, 8'h06, 24'h000000);
            if (o == 2'd0) add_txn(8'h83, 4, 8'hD8, fa);
            else           add_txn(8'h83, 4 + int'(ln), 8'h02, fa);
            if (wip + 1 <= int'(POLL_MAX_T)) begin
                passes = wip + 1;
                eerr = 2'd0;
            end else begin
                passes = int'(POLL_MAX_T);
                eerr = 2'd3;
            end
        end
        for (int p = 0; p < passes; p++) begin
            add_txn(8'h00, 2, 8'h05, 24'h000000);
            exp_q.push_back({1'b1, 12'h800, 8'h00});
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [23:0] fa, input logic [8:0] ln,
                          input int wip, input int stall, input bit poke, input string tag);
        int base, dbase, abase, rbase, cyc, passes;
        logic [1:0] eerr;
        bit bad;
        build(o, fa, ln, wip, eerr, passes, bad);
        if (stall >= 0) begin
            eerr = 2'd2;
            while (exp_q.size() > stall + 1) void'(exp_q.pop_back());
        end
        wip_n = wip;
        op_seq++;
        base  = obs.size();
        dbase = done_cnt;
        abase = act_cyc;
        rbase = rd_acks;
        stall_idx = (stall >= 0) ? base + stall : -1;
        @(negedge clk);
        op = o; faddr = fa; len = ln; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, bad ? 0 : 1);
        cyc = 0;
        while (done_cnt == dbase && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 8) begin op = 2'd2; faddr = 24'hFFFFFF; start = 1'b1; end
            if (poke && cyc == 9) start = 1'b0;
        end
        start = 1'b0;
        if (rd_acks != rbase) exp_status = last_status;
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_err"}, err, eerr);
        chk({tag, "_status"}, status, exp_status);
        if (poke) begin op = 2'd0; start = 1'b1; end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_fin"}, busy, 0);
        if (stall >= 0) begin
            chk({tag, "_wait_cycles"}, last_wait_run, ACK_TO_T);
            stall_release = 1'b1;
        end
        repeat (6) @(negedge clk);
        stall_release = 1'b0;
        stall_idx = -1;
        chk({tag, "_done_count"}, done_cnt - dbase, 1);
        chk({tag, "_idle"}, {busy, m_act}, 0);
        chk({tag, "_err_held"}, err, eerr);
        if (bad) chk({tag, "_no_act"}, act_cyc - abase, 0);
        if (!bad && stall < 0) chk({tag, "_polls"}, rd_acks - rbase, passes);
        chk({tag, "_n_access"}, obs.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < obs.size())
                chk($sformatf("%s_acc%0d", tag, i), obs[base + i], exp_q[i]);
    endtask

    initial begin : main
        int base, dbase, cyc, n, wip;
        logic [1:0]  ro;
        logic [23:0] rfa;
        logic [8:0]  rln;
        rst = 1'b1; start = 1'b0; op = 2'd0; faddr = 24'd0; len = 9'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, m_act, m_we, m_re, m_addr, m_wd, err, status}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        st_rand = 1'b0;
        run_op(2'd2, 24'h123456, 9'd0, 0, -1, 0, "op2_status0");
        st_rand = 1'b1;
        run_op(2'd0, 24'h1A0000, 9'd0, 3, -1, 0, "op0_wip3");
        run_op(2'd1, 24'h00AB00, 9'd256, 1, -1, 0, "op1_len256");
        run_op(2'd1, 24'h000100, 9'd0, 0, -1, 0, "op1_len0");
        run_op(2'd1, 24'h000200, 9'd257, 0, -1, 0, "op1_len257");
        run_op(2'd3, 24'h000300, 9'd4, 0, -1, 0, "op3");
        run_op(2'd1, 24'($urandom), 9'd1, 0, -1, 0, "op1_len1");
        run_op(2'd2, 24'($urandom), 9'd0, 2, -1, 0, "op2_wip_ignored");
        run_op(2'd1, 24'($urandom), 9'($urandom_range(1, 256)), 2, $urandom_range(0, 41), 0, "ack_timeout");
        run_op(2'd0, 24'($urandom), 9'd0, 9, -1, 0, "poll_limit");
        run_op(2'd1, 24'($urandom), 9'($urandom_range(1, 256)), 4, -1, 0, "poll_last_ok");
        run_op(2'd0, 24'($urandom), 9'd0, 1, -1, 1, "start_while_busy");

        // Reset while waiting for the acknowledge of the SE launch write.
        rfa = 24'($urandom);
        wip_n = 0;
        op_seq++;
        base  = obs.size();
        dbase = done_cnt;
        stall_idx = base + 17;
        @(negedge clk);
        op = 2'd0; faddr = rfa; len = 9'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (obs.size() < base + 18 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("rst_reached_se", obs.size() - base, 18);
        if (obs.size() >= base + 18) chk("rst_se_launch", obs[base + 17], {1'b0, 12'h00B, rfa[7:0]});
        repeat (5) @(negedge clk);
        chk("rst_busy_before", {busy, m_act}, 2'b11);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {busy, done, m_act, m_we, m_re, m_addr, m_wd, err, status}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        stall_release = 1'b1;
        repeat (8) @(negedge clk);
        stall_release = 1'b0;
        stall_idx = -1;
        exp_status = 8'h00;
        chk("rst_no_done", done_cnt - dbase, 0);
        chk("rst_idle_after_late_ack", {busy, done, m_act, err, status}, 0);
        chk("rst_no_new_access", obs.size() - base, 18);

        for (n = 0; n < 6; n++) begin
            ro  = 2'($urandom_range(0, 2));
            rfa = 24'($urandom);
            rln = 9'($urandom_range(1, 256));
            wip = $urandom_range(0, 6);
            run_op(ro, rfa, rln, wip, -1, 0, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
